// File: rtl/psimd_pkg.sv
// Shared definitions for the PSIMD writeback path.
//   XLEN       register / data width
//   NREG       architectural register count
//   REG_AW     register address width
//   wb_entry_t one queued writeback: destination, single/pair flag, lo/hi data
//   reg_mask   one-hot (or two-hot for a pair) mask of the registers a write touches
package psimd_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              single;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   hi;
  } wb_entry_t;

  // Callers only pass pair=1 when rd+1 does not wrap past the last register.
  function automatic logic [NREG-1:0] reg_mask(input logic [REG_AW-1:0] rd,
                                               input logic pair);
    logic [NREG-1:0] m;
    m = NREG'(1) << rd;
    if (pair) m = m | (NREG'(1) << (rd + REG_AW'(1)));
    return m;
  endfunction

endpackage

// File: rtl/psimd_wb_fifo.sv
// Result FIFO for the writeback sequencer.
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous: empty the FIFO at the next edge (wins over push/pop)
//   push, push_data   write an entry (ignored when full)
//   pop          remove the head entry (ignored when empty)
//   head         current head entry, valid while !empty
//   full, empty  occupancy flags
// Pointers carry one extra MSB so full and empty are distinguishable when the
// index bits match.
module psimd_wb_fifo
  import psimd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/psimd_wb_sequencer.sv
// Writeback sequencer feeding the PSIMD register-file write port.
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               drop queued results and clear the scoreboard
//   res_valid/res_ready execute-stage result handshake
//   res_rd, res_single  destination and single (rd only) / pair (rd, rd+1) select
//   res_lo, res_hi      data for rd and rd+1
//   chk_rs1..3, chk_busy   issue-stage hazard query against the pending scoreboard
//   wr_enable, reg_fti_ctrl, rd_address, dataout_1, dataout_2   register-file port
//   pair_wrap_err       pulse: a pair write at rd=31 was demoted to a single
//
// Handshake: a result transfers on a rising edge where res_valid && res_ready.
// res_ready depends combinationally on res_rd/res_single (WAW check), so the
// producer must hold valid and payload stable until the transfer happens.
// res_ready is also low in a flush cycle so a dropped result is never mistaken
// for an accepted one.
module psimd_wb_sequencer
  import psimd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [REG_AW-1:0] res_rd,
  input  logic              res_single,
  input  logic [XLEN-1:0]   res_lo,
  input  logic [XLEN-1:0]   res_hi,
  input  logic [REG_AW-1:0] chk_rs1,
  input  logic [REG_AW-1:0] chk_rs2,
  input  logic [REG_AW-1:0] chk_rs3,
  output logic              chk_busy,
  output logic              wr_enable,
  output logic              reg_fti_ctrl,
  output logic [REG_AW-1:0] rd_address,
  output logic [XLEN-1:0]   dataout_1,
  output logic [XLEN-1:0]   dataout_2,
  output logic              pair_wrap_err
);

  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   set_mask;
  logic [NREG-1:0]   clr_mask;
  logic [REG_AW-1:0] rd_next;
  logic              demote;
  logic              eff_single;
  logic              waw;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  wb_entry_t         push_entry;
  wb_entry_t         head;

  // A pair at the last register would spill into register 0; write lo only.
  assign rd_next    = res_rd + REG_AW'(1);
  assign demote     = !res_single && (res_rd == REG_AW'(NREG-1));
  assign eff_single = res_single || demote;
  assign waw        = busy[res_rd] || (!eff_single && busy[rd_next]);

  assign res_ready     = !fifo_full && !waw && !flush;
  assign accept        = res_valid && res_ready;
  assign pair_wrap_err = accept && demote;
  assign pop           = !fifo_empty && !flush;

  always_comb begin
    push_entry        = '0;
    push_entry.rd     = res_rd;
    push_entry.single = eff_single;
    push_entry.lo     = res_lo;
    push_entry.hi     = res_hi;
  end

  psimd_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (accept),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Scoreboard: set on accept, clear when the write is on the port.
  assign set_mask = accept    ? reg_mask(res_rd, !eff_single)         : '0;
  assign clr_mask = wr_enable ? reg_mask(rd_address, !reg_fti_ctrl)   : '0;

  // On flush the only surviving write is the one on the port, and it clears
  // its own bits at this same edge, so the whole scoreboard ends up zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     busy <= '0;
    else if (flush) busy <= '0;
    else            busy <= (busy & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_enable    <= 1'b0;
      reg_fti_ctrl <= 1'b1;
      rd_address   <= '0;
      dataout_1    <= '0;
      dataout_2    <= '0;
    end else begin
      wr_enable <= pop;
      if (pop) begin
        reg_fti_ctrl <= head.single;
        rd_address   <= head.rd;
        dataout_1    <= head.lo;
        dataout_2    <= head.hi;
      end
    end
  end

  assign chk_busy = busy[chk_rs1] || busy[chk_rs2] || busy[chk_rs3];

endmodule

// File: tb/tb_psimd_wb_sequencer.sv
// Directed bench for psimd_wb_sequencer. Inputs change on the falling edge and
// outputs are sampled on the falling edge (combinational outputs 1 time unit
// after the inputs settle).
module tb_psimd_wb_sequencer;
  import psimd_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              res_valid;
  logic              res_ready;
  logic [REG_AW-1:0] res_rd;
  logic              res_single;
  logic [XLEN-1:0]   res_lo;
  logic [XLEN-1:0]   res_hi;
  logic [REG_AW-1:0] chk_rs1;
  logic [REG_AW-1:0] chk_rs2;
  logic [REG_AW-1:0] chk_rs3;
  logic              chk_busy;
  logic              wr_enable;
  logic              reg_fti_ctrl;
  logic [REG_AW-1:0] rd_address;
  logic [XLEN-1:0]   dataout_1;
  logic [XLEN-1:0]   dataout_2;
  logic              pair_wrap_err;

  int checks = 0;
  int errors = 0;

  // Expected write order for the back-to-back burst: {rd, lo}.
  logic [REG_AW+XLEN-1:0] exp_q[$];
  logic [REG_AW+XLEN-1:0] exp_w;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  psimd_wb_sequencer #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_rd        (res_rd),
    .res_single    (res_single),
    .res_lo        (res_lo),
    .res_hi        (res_hi),
    .chk_rs1       (chk_rs1),
    .chk_rs2       (chk_rs2),
    .chk_rs3       (chk_rs3),
    .chk_busy      (chk_busy),
    .wr_enable     (wr_enable),
    .reg_fti_ctrl  (reg_fti_ctrl),
    .rd_address    (rd_address),
    .dataout_1     (dataout_1),
    .dataout_2     (dataout_2),
    .pair_wrap_err (pair_wrap_err)
  );

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [4:0] rd, input logic single,
                       input logic [63:0] lo, input logic [63:0] hi);
    res_valid  = 1'b1;
    res_rd     = rd;
    res_single = single;
    res_lo     = lo;
    res_hi     = hi;
  endtask

  task automatic idle();
    res_valid = 1'b0;
  endtask

  task automatic probe(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    chk_rs1 = a;
    chk_rs2 = b;
    chk_rs3 = c;
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A legal stream never sets and clears the same busy bit in one cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert ((dut.set_mask & dut.clr_mask) === '0) else begin
        errors++;
        $error("FAIL set_clr_overlap observed=%0h expected=0", dut.set_mask & dut.clr_mask);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0;
    res_valid = 1'b0; res_rd = '0; res_single = 1'b1; res_lo = '0; res_hi = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rs3 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", res_ready, 1);
    check("rst_wr_enable", wr_enable, 0);
    check("rst_fti", reg_fti_ctrl, 1);
    check("rst_rd_address", rd_address, 0);
    check("rst_dataout_1", dataout_1, 0);
    check("rst_dataout_2", dataout_2, 0);
    check("rst_wrap_err", pair_wrap_err, 0);
    check("rst_chk_busy", chk_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. Single write rd=5
    offer(5, 1, 64'hA5, 0); #1;
    check("t1_ready", res_ready, 1);
    @(negedge clk); idle(); probe(5, 0, 0);
    check("t1_busy_set", chk_busy, 1);
    check("t1_no_write_yet", wr_enable, 0);
    @(negedge clk);
    check("t1_wr_enable", wr_enable, 1);
    check("t1_fti", reg_fti_ctrl, 1);
    check("t1_rd", rd_address, 5);
    check("t1_d1", dataout_1, 64'hA5);
    check("t1_busy_during_write", chk_busy, 1);
    @(negedge clk);
    check("t1_wr_done", wr_enable, 0);
    check("t1_busy_clear", chk_busy, 0);

    // 2. Pair write rd=6/7
    offer(6, 0, 64'h1, 64'h2);
    @(negedge clk); idle();
    probe(6, 0, 0); check("t2_busy6", chk_busy, 1);
    probe(7, 0, 0); check("t2_busy7", chk_busy, 1);
    @(negedge clk);
    check("t2_wr_enable", wr_enable, 1);
    check("t2_fti", reg_fti_ctrl, 0);
    check("t2_rd", rd_address, 6);
    check("t2_d1", dataout_1, 64'h1);
    check("t2_d2", dataout_2, 64'h2);
    @(negedge clk);
    check("t2_wr_done", wr_enable, 0);
    probe(6, 0, 0); check("t2_busy6_clear", chk_busy, 0);
    probe(7, 0, 0); check("t2_busy7_clear", chk_busy, 0);

    // 3. WAW stall: rd=7 pending, pair rd=6 must wait
    offer(7, 1, 64'h77, 0);
    @(negedge clk); offer(6, 0, 64'h10, 64'h11); #1;
    check("t3_stall_a", res_ready, 0);
    @(negedge clk);
    check("t3_wr7", wr_enable, 1);
    check("t3_wr7_rd", rd_address, 7);
    check("t3_stall_b", res_ready, 0);
    @(negedge clk); #1;
    check("t3_released", res_ready, 1);
    check("t3_port_idle", wr_enable, 0);
    @(negedge clk); idle();
    check("t3_queued", wr_enable, 0);
    @(negedge clk);
    check("t3_wr6", wr_enable, 1);
    check("t3_wr6_rd", rd_address, 6);
    check("t3_wr6_fti", reg_fti_ctrl, 0);
    check("t3_wr6_d1", dataout_1, 64'h10);
    check("t3_wr6_d2", dataout_2, 64'h11);
    @(negedge clk);
    check("t3_done", wr_enable, 0);
    probe(6, 7, 0); check("t3_busy_clear", chk_busy, 0);

    // 4. Pair at rd=31 is demoted
    offer(31, 0, 64'h31F, 64'hDEAD); #1;
    check("t4_wrap_pulse", pair_wrap_err, 1);
    check("t4_ready", res_ready, 1);
    @(negedge clk); idle(); #1;
    check("t4_wrap_gone", pair_wrap_err, 0);
    probe(31, 0, 0); check("t4_busy31", chk_busy, 1);
    probe(0, 0, 0);  check("t4_busy0_never", chk_busy, 0);
    @(negedge clk);
    check("t4_wr_enable", wr_enable, 1);
    check("t4_fti", reg_fti_ctrl, 1);
    check("t4_rd", rd_address, 31);
    check("t4_d1", dataout_1, 64'h31F);
    check("t4_busy0_write", chk_busy, 0);
    @(negedge clk);
    check("t4_done", wr_enable, 0);
    probe(31, 0, 0); check("t4_busy31_clear", chk_busy, 0);

    // 5. Five back-to-back singles. The drain pops every cycle, so the queue
    //    never holds more than one entry and ready stays high throughout.
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      if (i < 5) begin
        offer(5'(10 + i), 1, 64'h100 + 64'(i), 0);
        exp_q.push_back({5'(10 + i), 64'h100 + 64'(i)});
        #1;
        check("t5_ready", res_ready, 1);
      end else begin
        idle();
      end
      if (i >= 2) begin
        exp_w = exp_q.pop_front();
        check("t5_wr_enable", wr_enable, 1);
        check("t5_rd", rd_address, exp_w[XLEN +: REG_AW]);
        check("t5_d1", dataout_1, exp_w[XLEN-1:0]);
      end else begin
        check("t5_fill", wr_enable, 0);
      end
    end
    @(negedge clk);
    check("t5_done", wr_enable, 0);

    // 6a. Flush: rd=20 on the port completes, queued rd=21 is dropped
    offer(20, 1, 64'h200, 0);
    @(negedge clk); offer(21, 1, 64'h201, 0); #1;
    check("t6_ready", res_ready, 1);
    @(negedge clk); idle(); flush = 1'b1; #1;
    check("t6_port_write", wr_enable, 1);
    check("t6_port_rd", rd_address, 20);
    check("t6_port_d1", dataout_1, 64'h200);
    check("t6_flush_ready", res_ready, 0);
    probe(21, 0, 0); check("t6_busy21", chk_busy, 1);
    @(negedge clk); flush = 1'b0;
    check("t6_dropped", wr_enable, 0);
    probe(20, 21, 0); check("t6_busy_clear", chk_busy, 0);
    @(negedge clk);
    check("t6_still_idle", wr_enable, 0);

    // 6b. Asynchronous reset while a write is on the port
    offer(22, 1, 64'h222, 0);
    @(negedge clk); idle();
    @(negedge clk);
    check("t6_pre_reset_write", wr_enable, 1);
    probe(22, 0, 0); check("t6_pre_reset_busy", chk_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_wr_enable", wr_enable, 0);
    check("t6_rst_fti", reg_fti_ctrl, 1);
    check("t6_rst_rd", rd_address, 0);
    check("t6_rst_d1", dataout_1, 0);
    check("t6_rst_busy", chk_busy, 0);
    check("t6_rst_ready", res_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("t6_after_reset", wr_enable, 0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
